// File: rtl/useq_arith_pkg.sv
// rtl/useq_arith_pkg.sv - opcode and FSM state definitions for the unsigned arithmetic unit
package useq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/useq_iter_step.sv
// rtl/useq_iter_step.sv - one combinational iteration of shift-add multiply or restoring divide
module useq_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mc_i,
    input  logic [WIDTH-1:0]   mp_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mc_o,
    output logic [WIDTH-1:0]   mp_o
);

    // Partial remainder shifted left by one with the next dividend bit appended
    logic [WIDTH:0] shifted_hi;
    logic [WIDTH:0] trial_diff;
    logic           trial_ok;

    // Multiply: acc accumulates the shifted multiplicand for each set multiplier bit.
    // Divide: acc holds {remainder, quotient}; quotient bits enter from the bottom.
    always_comb begin
        acc_o      = acc_i;
        mc_o       = mc_i;
        mp_o       = mp_i;
        shifted_hi = acc_i[2*WIDTH-1:WIDTH-1];
        trial_diff = shifted_hi - {1'b0, mp_i};
        trial_ok   = (shifted_hi >= {1'b0, mp_i});
        if (is_div_i) begin
            if (trial_ok) begin
                acc_o = {trial_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shifted_hi[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = acc_i + (mp_i[0] ? mc_i : {(2*WIDTH){1'b0}});
            mc_o  = mc_i << 1;
            mp_o  = mp_i >> 1;
        end
    end

endmodule

// File: rtl/useq_arith_unit.sv
// rtl/useq_arith_unit.sv - multi-cycle unsigned add/sub/mul/div unit; optional USEQ_ARITH_EARLY_TERM_EN
module useq_arith_unit
    import useq_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               carry_q, carry_d;
    logic               dbz_q, dbz_d;

    logic [2*WIDTH-1:0] acc_s;
    logic [2*WIDTH-1:0] mc_s;
    logic [WIDTH-1:0]   mp_s;
    logic [WIDTH:0]     sum_w;
    logic               last_iter;

    useq_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (op_q == OP_DIV),
        .acc_i    (acc_q),
        .mc_i     (mc_q),
        .mp_i     (mp_q),
        .acc_o    (acc_s),
        .mc_o     (mc_s),
        .mp_o     (mp_s)
    );

    assign sum_w       = {1'b0, a} + {1'b0, b};
    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;

    // Decide whether the iteration running this cycle is the final one
    always_comb begin
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef USEQ_ARITH_EARLY_TERM_EN
        // Once no multiplier bits remain, later iterations would add nothing
        if ((op_q == OP_MUL) && (mp_s == '0)) begin
            last_iter = 1'b1;
        end
`endif
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, hold results in DONE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (opcode)
                        OP_ADD: begin
                            lo_d    = sum_w[WIDTH-1:0];
                            hi_d    = '0;
                            carry_d = sum_w[WIDTH];
                            dbz_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        OP_SUB: begin
                            lo_d    = a - b;
                            hi_d    = '0;
                            carry_d = (a < b);
                            dbz_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        default: begin
                            op_d    = opcode;
                            cnt_d   = '0;
                            mc_d    = {{WIDTH{1'b0}}, a};
                            mp_d    = b;
                            acc_d   = (opcode == OP_DIV) ? {{WIDTH{1'b0}}, a} : '0;
                            state_d = ST_BUSY;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                acc_d = acc_s;
                mc_d  = mc_s;
                mp_d  = mp_s;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = ST_DONE;
                    carry_d = 1'b0;
                    lo_d    = acc_s[WIDTH-1:0];
                    hi_d    = acc_s[2*WIDTH-1:WIDTH];
                    dbz_d   = 1'b0;
                    // For divide mc holds the untouched dividend
                    if ((op_q == OP_DIV) && (mp_q == '0)) begin
                        lo_d  = '1;
                        hi_d  = mc_q[WIDTH-1:0];
                        dbz_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: doc/useq_arith_unit.md
Name: useq_arith_unit

Overview:
- Parametrised, multi-cycle unsigned arithmetic unit for the CPU ALU's unsigned path.
- Supports add, subtract, multiply (full 2*WIDTH product) and divide (quotient plus remainder).
- Add/sub complete in 1 cycle; multiply is iterative shift-add and divide is iterative restoring, each taking WIDTH cycles.
- Valid/ready handshakes on both sides let the control unit stall on long operations.

Parameters:
- WIDTH, 32, operand width in bits (>= 4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- opcode  in  2  00 add, 01 sub, 10 mul, 11 div
- a  in  WIDTH  operand A (dividend / multiplicand)
- b  in  WIDTH  operand B (divisor / multiplier)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result_lo  out  WIDTH  sum / difference / product[WIDTH-1:0] / quotient
- result_hi  out  WIDTH  0 / 0 / product[2W-1:W] / remainder
- carry  out  1  add carry-out; sub borrow (a<b); 0 otherwise
- div_by_zero  out  1  set for a div with b==0

Behaviour:
- Decided: one clock `clk`; `reset` is synchronous and active-high.
- Reset (any state, including mid-operation):
  - state to IDLE; in_ready=1.
  - out_valid, result_lo, result_hi, carry, div_by_zero all 0.
  - The in-flight operation is discarded.
- FSM states:
  - IDLE: in_ready=1.
    - in_valid with add/sub: compute and register the result, go to DONE.
    - in_valid with mul/div: latch operands, counter=0, go to BUSY.
  - BUSY: in_ready=0. One iteration per cycle. When counter reaches WIDTH-1, register the result and go to DONE.
  - DONE: out_valid=1 and outputs held stable. When out_ready=1, go to IDLE, clear out_valid, set in_ready=1.
- Acceptance: a request is accepted on a cycle with in_valid && in_ready (call it T).
- Latency:
  - add/sub: out_valid=1 at T+1.
  - mul/div: out_valid=1 at T+WIDTH+1.
  - out_valid and out_ready high in the same cycle retires the result; the next request can be accepted the following cycle. No same-cycle accept and retire.
- in_valid while in_ready=0 is ignored. The requester must hold its request.
- Outputs stay constant from out_valid rising until retirement (no glitching under back-pressure).
- Arithmetic: all unsigned, modulo 2^WIDTH except mul.
  - add: {carry, result_lo} = a+b.
  - sub: result_lo = a-b mod 2^WIDTH; carry = (a<b).
  - mul: {result_hi, result_lo} = a*b exact.
  - div: result_lo = a/b, result_hi = a%b.
- Divide by zero:
  - Takes the normal WIDTH-cycle latency.
  - result_lo = all ones, result_hi = a, div_by_zero=1, carry=0.
- div_by_zero is 0 for every other op.
- Opcode and operand inputs are sampled only at acceptance. Changes during BUSY have no effect.

Optional Feature:
- Macro: USEQ_ARITH_EARLY_TERM_EN.
- Defined:
  - mul: goes to DONE once the remaining (shifted) multiplier bits are all zero. Latency is T+1+max(1, index of highest set bit of b + 1); b==0 gives T+2.
  - div: unchanged.
  - Results are identical to the macro-off build.
- Undefined: fixed latency as above. The early-termination logic is absent.

Decomposition:
- Package useq_arith_pkg:
  - opcode localparams OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - FSM state encoding ST_IDLE/ST_BUSY/ST_DONE.
- Sub-module useq_iter_step: combinational single iteration.
  - mul mode: conditional add, shift right.
  - div mode: shift-left, trial subtract, restore.
  - Instantiated once in the top, which owns the registers, counter and FSM.

Test Plan (WIDTH=32 unless stated):
- add a=0xFFFFFFFF, b=1 -> out_valid at T+1, result_lo=0, result_hi=0, carry=1. Sub a=3, b=5 -> result_lo=0xFFFFFFFE, carry=1.
- mul a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid at T+33, result_hi=0xFFFFFFFE, result_lo=0x00000001. With EARLY_TERM, mul a=7, b=2 -> out_valid at T+3, result_lo=14.
- div a=100, b=7 -> T+33, result_lo=14, result_hi=2, div_by_zero=0. Div a=5, b=0 -> result_lo=0xFFFFFFFF, result_hi=5, div_by_zero=1.
- Back-pressure: hold out_ready=0 for 10 cycles after div completes -> outputs stable, in_ready=0, a new in_valid is ignored. Release -> retire, in_ready=1 the next cycle.
- Assert reset at cycle 10 of a mul -> next cycle IDLE, all outputs 0, in_ready=1. A fresh add 2+2 then yields 4 at T+1.
- WIDTH=8 random mul/div/add/sub (2000 ops, random out_ready) vs reference model -> all results and flags match, latency per rules above.
